// File: rtl/axi_wr_burst_split_if.sv
// AXI4 write-channel bundle (AW, W, B) shared by the upstream and downstream sides
// of the burst splitter.
interface axi_wr_burst_split_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_wr_burst_split.sv
// Splits long INCR write bursts into sub-bursts of at most MAX_BURST_LEN beats and
// merges the sub-burst write responses into a single upstream response.
module axi_wr_burst_split #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH      = 8,
    parameter int unsigned MAX_BURST_LEN = 16
) (
    input logic                  clk,
    input logic                  rst,
    axi_wr_burst_split_if.slave  s_axi,
    axi_wr_burst_split_if.master m_axi
);
    typedef enum logic [1:0] {StIdle, StIssue, StData, StResp} state_e;

    localparam logic [8:0] MaxLen = 9'(MAX_BURST_LEN);

    state_e                state_q, state_d;
    logic                  awready_q, awready_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic                  lock_q, lock_d;
    logic [3:0]            cache_q, cache_d;
    logic [2:0]            prot_q, prot_d;
    logic [8:0]            remaining_q, remaining_d;
    logic [8:0]            issued_q, issued_d;
    logic [8:0]            received_q, received_d;
    logic [1:0]            resp_acc_q, resp_acc_d;
    logic [8:0]            sub_len_q, sub_len_d;
    logic [8:0]            beat_q, beat_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [8:0]            cur_len;
    logic                  unused_sigs;

    assign unused_sigs = ^{s_axi.wlast, m_axi.bid};

    // FIXED and WRAP are never split; they are at most 16 beats anyway.
    always_comb begin
        cur_len = remaining_q;
        if (burst_q == 2'b01 && remaining_q > MaxLen) cur_len = MaxLen;
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        size_d      = size_q;
        burst_d     = burst_q;
        lock_d      = lock_q;
        cache_d     = cache_q;
        prot_d      = prot_q;
        remaining_d = remaining_q;
        issued_d    = issued_q;
        received_d  = received_q;
        resp_acc_d  = resp_acc_q;
        sub_len_d   = sub_len_q;
        beat_d      = beat_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;

        s_axi.awready = awready_q;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = bvalid_q;
        s_axi.bid     = bid_q;
        s_axi.bresp   = bresp_q;
        m_axi.awvalid = 1'b0;
        m_axi.awid    = '0;
        m_axi.awaddr  = '0;
        m_axi.awlen   = '0;
        m_axi.awsize  = '0;
        m_axi.awburst = '0;
        m_axi.awlock  = 1'b0;
        m_axi.awcache = '0;
        m_axi.awprot  = '0;
        m_axi.wvalid  = 1'b0;
        m_axi.wdata   = '0;
        m_axi.wstrb   = '0;
        m_axi.wlast   = 1'b0;
        m_axi.bready  = (received_q < issued_q) && !bvalid_q;

        // Sub-burst responses are collected in any state as they come back.
        if (m_axi.bvalid && m_axi.bready) begin
            received_d = received_q + 9'd1;
            if (m_axi.bresp > resp_acc_q) resp_acc_d = m_axi.bresp;
        end

        unique case (state_q)
            StIdle: begin
                if (s_axi.awvalid && awready_q) begin
                    id_d        = s_axi.awid;
                    addr_d      = s_axi.awaddr;
                    size_d      = s_axi.awsize;
                    burst_d     = s_axi.awburst;
                    lock_d      = s_axi.awlock;
                    cache_d     = s_axi.awcache;
                    prot_d      = s_axi.awprot;
                    remaining_d = {1'b0, s_axi.awlen} + 9'd1;
                    issued_d    = '0;
                    received_d  = '0;
                    resp_acc_d  = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                m_axi.awvalid = 1'b1;
                m_axi.awid    = id_q;
                m_axi.awaddr  = addr_q;
                m_axi.awlen   = 8'(cur_len - 9'd1);
                m_axi.awsize  = size_q;
                m_axi.awburst = burst_q;
                m_axi.awlock  = lock_q;
                m_axi.awcache = cache_q;
                m_axi.awprot  = prot_q;
                if (m_axi.awready) begin
                    sub_len_d = cur_len;
                    beat_d    = '0;
                    issued_d  = issued_q + 9'd1;
                    state_d   = StData;
                end
            end
            StData: begin
                m_axi.wvalid = s_axi.wvalid;
                m_axi.wdata  = s_axi.wdata;
                m_axi.wstrb  = s_axi.wstrb;
                m_axi.wlast  = (beat_q == sub_len_q - 9'd1);
                s_axi.wready = m_axi.wready;
                if (s_axi.wvalid && m_axi.wready) begin
                    beat_d = beat_q + 9'd1;
                    if (m_axi.wlast) begin
                        remaining_d = remaining_q - sub_len_q;
                        if (burst_q == 2'b01) addr_d = addr_q + (ADDR_WIDTH'(sub_len_q) << size_q);
                        state_d = (remaining_q == sub_len_q) ? StResp : StIssue;
                    end
                end
            end
            StResp: begin
                if (!bvalid_q && received_q == issued_q) begin
                    bvalid_d = 1'b1;
                    bid_d    = id_q;
                    // EXOKAY cannot be honoured once the access was split.
                    bresp_d  = (issued_q > 9'd1 && resp_acc_q == 2'b01) ? 2'b00 : resp_acc_q;
                end else if (bvalid_q && s_axi.bready) begin
                    bvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        awready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            awready_q   <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            lock_q      <= 1'b0;
            cache_q     <= '0;
            prot_q      <= '0;
            remaining_q <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            resp_acc_q  <= '0;
            sub_len_q   <= '0;
            beat_q      <= '0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= '0;
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            lock_q      <= lock_d;
            cache_q     <= cache_d;
            prot_q      <= prot_d;
            remaining_q <= remaining_d;
            issued_q    <= issued_d;
            received_q  <= received_d;
            resp_acc_q  <= resp_acc_d;
            sub_len_q   <= sub_len_d;
            beat_q      <= beat_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
        end
    end
endmodule

// File: tb/tb_axi_wr_burst_split.sv
// Directed bench for axi_wr_burst_split: upstream master and downstream slave models
// driven cycle by cycle on the falling edge.
module tb_axi_wr_burst_split;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_wr_burst_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) s_axi ();
    axi_wr_burst_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) m_axi ();

    axi_wr_burst_split #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_BURST_LEN(16)
    ) dut (
        .clk(clk), .rst(rst), .s_axi(s_axi), .m_axi(m_axi)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [AW-1:0] aw_addr[$];
    logic [7:0]    aw_len[$];
    logic [1:0]    aw_burst[$];
    logic [IW-1:0] aw_id[$];
    logic [3:0]    aw_cache[$];
    logic [2:0]    aw_prot[$];
    int            wlast_at[$];
    logic [1:0]    resp_list[$];
    int w_count, data_err, hold_err, awready_err, sb_count, mb_count, sb_mb_at, bv_hold;
    logic [IW-1:0] sb_id;
    logic [1:0]    sb_resp;
    bit            timed_out;

    task automatic drive_idle();
        s_axi.awvalid = 0; s_axi.awid = 0; s_axi.awaddr = 0; s_axi.awlen = 0;
        s_axi.awsize = 0; s_axi.awburst = 0; s_axi.awlock = 0; s_axi.awcache = 0;
        s_axi.awprot = 0; s_axi.wvalid = 0; s_axi.wdata = 0; s_axi.wstrb = 0;
        s_axi.wlast = 0; s_axi.bready = 0;
        m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.bid = 0; m_axi.bresp = 0;
    endtask

    // Runs one upstream transaction; returns early once abort_beat downstream beats passed.
    task automatic run_txn(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit toggle_wready,
                           input int bready_delay, input int abort_beat);
        int sent = 0, pending = 0, b_idx = 0, cyc = 0, bv_cycles = 0, tail = -1;
        bit aw_done = 0, done = 0, held_valid = 0;
        logic [IW-1:0] held_id = '0;
        logic [1:0] held_resp = '0;
        aw_addr.delete(); aw_len.delete(); aw_burst.delete(); aw_id.delete();
        aw_cache.delete(); aw_prot.delete(); wlast_at.delete();
        w_count = 0; data_err = 0; hold_err = 0; awready_err = 0; sb_count = 0;
        mb_count = 0; sb_mb_at = -1; bv_hold = 0; sb_id = 'x; sb_resp = 'x; timed_out = 0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin timed_out = 1; break; end
            s_axi.awvalid = !aw_done; s_axi.awid = id; s_axi.awaddr = addr;
            s_axi.awlen = len; s_axi.awsize = size; s_axi.awburst = burst;
            s_axi.awlock = 0; s_axi.awcache = 4'h3; s_axi.awprot = 3'h2;
            s_axi.wvalid = (sent <= int'(len));
            s_axi.wdata = 32'hA500_0000 + sent; s_axi.wstrb = 4'hF;
            s_axi.wlast = (sent == int'(len));
            s_axi.bready = (bv_cycles >= bready_delay);
            m_axi.awready = 1;
            m_axi.wready = toggle_wready ? (cyc % 2 == 0) : 1'b1;
            m_axi.bvalid = (pending > 0);
            m_axi.bresp = (b_idx < resp_list.size()) ? resp_list[b_idx] : 2'b00;
            m_axi.bid = 8'hEE;
            #1;
            if (aw_done && sb_count == 0 && s_axi.awready) awready_err++;
            if (s_axi.awvalid && s_axi.awready) aw_done = 1;
            if (m_axi.awvalid && m_axi.awready) begin
                aw_addr.push_back(m_axi.awaddr); aw_len.push_back(m_axi.awlen);
                aw_burst.push_back(m_axi.awburst); aw_id.push_back(m_axi.awid);
                aw_cache.push_back(m_axi.awcache); aw_prot.push_back(m_axi.awprot);
            end
            if (s_axi.wvalid && s_axi.wready) sent++;
            if (m_axi.wvalid && m_axi.wready) begin
                if (m_axi.wdata !== 32'hA500_0000 + w_count) data_err++;
                w_count++;
                if (m_axi.wlast) begin wlast_at.push_back(w_count); pending++; end
            end
            if (m_axi.bvalid && m_axi.bready) begin pending--; b_idx++; mb_count++; end
            if (s_axi.bvalid) begin
                if (held_valid && (s_axi.bid !== held_id || s_axi.bresp !== held_resp))
                    hold_err++;
                held_valid = 1; held_id = s_axi.bid; held_resp = s_axi.bresp;
                if (s_axi.bready) begin
                    sb_count++; sb_id = s_axi.bid; sb_resp = s_axi.bresp;
                    sb_mb_at = mb_count; held_valid = 0;
                    if (tail < 0) tail = 5;
                end else begin
                    bv_cycles++; bv_hold++;
                end
            end
            if (tail > 0) begin tail--; if (tail == 0) done = 1; end
            if (abort_beat > 0 && w_count >= abort_beat) done = 1;
        end
        if (abort_beat == 0) drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({s_axi.awready, s_axi.wready, s_axi.bvalid, m_axi.awvalid, m_axi.wvalid,
             m_axi.bready} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 000000", {s_axi.awready, s_axi.wready,
                     s_axi.bvalid, m_axi.awvalid, m_axi.wvalid, m_axi.bready});
        end
        tests_run++;
        if ({m_axi.awaddr, m_axi.awid, m_axi.awlen, m_axi.wdata, s_axi.bid, s_axi.bresp} !== '0)
        begin
            tests_failed++;
            $display("FAIL reset_fields: awaddr %h awid %h wdata %h bid %h, want all 0",
                     m_axi.awaddr, m_axi.awid, m_axi.wdata, s_axi.bid);
        end
        rst = 0;
        @(negedge clk);
        tests_run++;
        if (s_axi.awready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_awready_rise: got %b want 1", s_axi.awready);
        end
    endtask

    task automatic test_single();
        resp_list = '{2'b00};
        run_txn(8'h05, 32'h1000, 8'd3, 3'd2, 2'b01, 0, 0, 0);
        tests_run++;
        if (timed_out || aw_addr.size() != 1 || aw_addr[0] !== 32'h1000 || aw_len[0] !== 8'd3)
        begin
            tests_failed++;
            $display("FAIL single_aw: count %0d addr %h len %0d, want 1 @1000 len 3",
                     aw_addr.size(), aw_addr[0], aw_len[0]);
        end
        tests_run++;
        if (aw_id[0] !== 8'h05 || aw_cache[0] !== 4'h3 || aw_prot[0] !== 3'h2) begin
            tests_failed++;
            $display("FAIL single_attrs: id %h cache %h prot %h, want 05 3 2",
                     aw_id[0], aw_cache[0], aw_prot[0]);
        end
        tests_run++;
        if (wlast_at.size() != 1 || wlast_at[0] != 4 || data_err != 0) begin
            tests_failed++;
            $display("FAIL single_w: wlast count %0d at %0d data_err %0d, want 1 at 4, 0",
                     wlast_at.size(), wlast_at[0], data_err);
        end
        tests_run++;
        if (sb_count != 1 || sb_id !== 8'h05 || sb_resp !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_b: count %0d bid %h bresp %b, want 1 05 00",
                     sb_count, sb_id, sb_resp);
        end
        resp_list = '{2'b01};
        run_txn(8'h06, 32'h1100, 8'd3, 3'd2, 2'b01, 0, 0, 0);
        tests_run++;
        if (sb_count != 1 || sb_resp !== 2'b01) begin
            tests_failed++;
            $display("FAIL single_exokay: count %0d bresp %b, want 1 01", sb_count, sb_resp);
        end
    endtask

    task automatic test_split();
        resp_list = '{2'b00, 2'b10, 2'b00};
        run_txn(8'h12, 32'h2000, 8'd39, 3'd2, 2'b01, 0, 0, 0);
        tests_run++;
        if (timed_out || aw_addr.size() != 3 || aw_addr[0] !== 32'h2000 ||
            aw_addr[1] !== 32'h2040 || aw_addr[2] !== 32'h2080) begin
            tests_failed++;
            $display("FAIL split_addr: count %0d %h %h %h, want 3 2000 2040 2080",
                     aw_addr.size(), aw_addr[0], aw_addr[1], aw_addr[2]);
        end
        tests_run++;
        if (aw_len[0] !== 8'd15 || aw_len[1] !== 8'd15 || aw_len[2] !== 8'd7) begin
            tests_failed++;
            $display("FAIL split_len: %0d %0d %0d, want 15 15 7", aw_len[0], aw_len[1], aw_len[2]);
        end
        tests_run++;
        if (wlast_at.size() != 3 || wlast_at[0] != 16 || wlast_at[1] != 32 ||
            wlast_at[2] != 40 || w_count != 40 || data_err != 0) begin
            tests_failed++;
            $display("FAIL split_wlast: n %0d at %0d/%0d/%0d beats %0d derr %0d, want 16/32/40",
                     wlast_at.size(), wlast_at[0], wlast_at[1], wlast_at[2], w_count, data_err);
        end
        tests_run++;
        if (sb_count != 1 || sb_mb_at != 3 || sb_id !== 8'h12 || sb_resp !== 2'b10) begin
            tests_failed++;
            $display("FAIL split_b: count %0d after_mb %0d bid %h bresp %b, want 1 3 12 10",
                     sb_count, sb_mb_at, sb_id, sb_resp);
        end
        resp_list = '{2'b01, 2'b01, 2'b01};
        run_txn(8'h13, 32'h2000, 8'd39, 3'd2, 2'b01, 0, 0, 0);
        tests_run++;
        if (sb_count != 1 || sb_resp !== 2'b00) begin
            tests_failed++;
            $display("FAIL split_exokay: count %0d bresp %b, want 1 00", sb_count, sb_resp);
        end
    endtask

    task automatic test_boundary();
        resp_list = '{2'b00, 2'b00, 2'b00};
        run_txn(8'h20, 32'h4000, 8'd15, 3'd2, 2'b01, 0, 0, 0);
        tests_run++;
        if (aw_addr.size() != 1 || aw_len[0] !== 8'd15 || sb_count != 1) begin
            tests_failed++;
            $display("FAIL bound_16: count %0d len %0d sb %0d, want 1 15 1",
                     aw_addr.size(), aw_len[0], sb_count);
        end
        run_txn(8'h21, 32'h5000, 8'd16, 3'd2, 2'b01, 0, 0, 0);
        tests_run++;
        if (aw_addr.size() != 2 || aw_len[0] !== 8'd15 || aw_len[1] !== 8'd0 ||
            aw_addr[1] !== 32'h5040 || wlast_at.size() != 2 || wlast_at[1] != 17) begin
            tests_failed++;
            $display("FAIL bound_17: count %0d lens %0d/%0d addr1 %h, want 2 15/0 5040",
                     aw_addr.size(), aw_len[0], aw_len[1], aw_addr[1]);
        end
        run_txn(8'h22, 32'h0100, 8'd31, 3'd0, 2'b01, 0, 0, 0);
        tests_run++;
        if (aw_addr.size() != 2 || aw_addr[0] !== 32'h0100 || aw_addr[1] !== 32'h0110) begin
            tests_failed++;
            $display("FAIL bound_size0: count %0d addrs %h %h, want 2 0100 0110",
                     aw_addr.size(), aw_addr[0], aw_addr[1]);
        end
    endtask

    task automatic test_wrap();
        resp_list = '{2'b00};
        run_txn(8'h07, 32'h0030, 8'd7, 3'd2, 2'b10, 0, 0, 0);
        tests_run++;
        if (aw_addr.size() != 1 || aw_burst[0] !== 2'b10 || aw_len[0] !== 8'd7 ||
            aw_addr[0] !== 32'h0030) begin
            tests_failed++;
            $display("FAIL wrap_aw: count %0d burst %b len %0d addr %h, want 1 10 7 0030",
                     aw_addr.size(), aw_burst[0], aw_len[0], aw_addr[0]);
        end
        tests_run++;
        if (wlast_at.size() != 1 || wlast_at[0] != 8 || sb_count != 1) begin
            tests_failed++;
            $display("FAIL wrap_w: wlast n %0d at %0d sb %0d, want 1 at 8, 1",
                     wlast_at.size(), wlast_at[0], sb_count);
        end
    endtask

    task automatic test_backpressure();
        resp_list = '{2'b00, 2'b00, 2'b00};
        run_txn(8'h33, 32'h3000, 8'd39, 3'd2, 2'b01, 1, 5, 0);
        tests_run++;
        if (timed_out || w_count != 40 || data_err != 0 || wlast_at.size() != 3 ||
            wlast_at[2] != 40) begin
            tests_failed++;
            $display("FAIL bp_beats: beats %0d derr %0d wlast n %0d, want 40 0 3",
                     w_count, data_err, wlast_at.size());
        end
        tests_run++;
        if (bv_hold != 5 || hold_err != 0 || sb_count != 1 || sb_id !== 8'h33) begin
            tests_failed++;
            $display("FAIL bp_bhold: held %0d herr %0d sb %0d bid %h, want 5 0 1 33",
                     bv_hold, hold_err, sb_count, sb_id);
        end
        tests_run++;
        if (awready_err != 0) begin
            tests_failed++;
            $display("FAIL bp_awready: early awready cycles %0d, want 0", awready_err);
        end
    endtask

    task automatic test_reset_mid();
        resp_list = '{2'b00, 2'b00, 2'b00};
        run_txn(8'h44, 32'h6000, 8'd39, 3'd2, 2'b01, 0, 0, 20);
        rst = 1;
        drive_idle();
        @(negedge clk);
        tests_run++;
        if ({s_axi.awready, s_axi.wready, s_axi.bvalid, m_axi.awvalid, m_axi.wvalid,
             m_axi.bready} !== 6'b0) begin
            tests_failed++;
            $display("FAIL midrst_ctrl: got %b want 000000", {s_axi.awready, s_axi.wready,
                     s_axi.bvalid, m_axi.awvalid, m_axi.wvalid, m_axi.bready});
        end
        rst = 0;
        @(negedge clk);
        tests_run++;
        if (s_axi.awready !== 1'b1 || s_axi.bvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_release: awready %b bvalid %b, want 1 0",
                     s_axi.awready, s_axi.bvalid);
        end
        resp_list = '{2'b00};
        run_txn(8'h45, 32'h7000, 8'd3, 3'd2, 2'b01, 0, 0, 0);
        tests_run++;
        if (timed_out || aw_addr.size() != 1 || aw_addr[0] !== 32'h7000 || w_count != 4 ||
            sb_count != 1 || sb_id !== 8'h45 || sb_resp !== 2'b00) begin
            tests_failed++;
            $display("FAIL midrst_after: aw %0d beats %0d sb %0d bid %h, want 1 4 1 45",
                     aw_addr.size(), w_count, sb_count, sb_id);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_split();
        test_boundary();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
